// File: rtl/assoc_cache_if.sv
// CPU request/response and word-serial memory signals of assoc_cache.
// The cache connects through the slave modport; the CPU/memory side uses master.
interface assoc_cache_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned WORD_W = 32
);
   logic              cpuRead;
   logic              cpuWrite;
   logic [ADDR_W-1:0] cpuAddr;
   logic [WORD_W-1:0] cpuData;
   logic              hit;
   logic [WORD_W-1:0] rData;
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [WORD_W-1:0] wData;
   logic [WORD_W-1:0] memData;
   logic              done_r;
   logic              done_w;

   modport slave (
      input  cpuRead, cpuWrite, cpuAddr, cpuData, memData, done_r, done_w,
      output hit, rData, read, write, addr, wData
   );

   modport master (
      output cpuRead, cpuWrite, cpuAddr, cpuData, memData, done_r, done_w,
      input  hit, rData, read, write, addr, wData
   );
endinterface

// File: rtl/assoc_cache.sv
// N-way set-associative write-back, write-allocate cache with LRU replacement.
// CPU side holds a level request until hit; memory side moves one word per handshake.
module assoc_cache #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned WORD_W = 32,
   parameter int unsigned SETS   = 4,
   parameter int unsigned WAYS   = 2,
   parameter int unsigned WORDS  = 4
) (
   input logic          clock,
   input logic          reset,
   assoc_cache_if.slave bus_io
);
   localparam int unsigned WSEL_W = $clog2(WORDS);
   localparam int unsigned IDX_W  = $clog2(SETS);
   localparam int unsigned TAG_W  = ADDR_W - WSEL_W - 2 - IDX_W;
   localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef logic [TAG_W-1:0]  tag_t;
   typedef logic [IDX_W-1:0]  idx_t;
   typedef logic [WSEL_W-1:0] wsel_t;
   typedef logic [WAY_W-1:0]  way_t;
   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [2:0] {StIdle, StLookup, StWb, StRefill, StResp} state_e;

   localparam wsel_t LastWord  = wsel_t'(WORDS - 1);
   localparam way_t  OldestAge = way_t'(WAYS - 1);

   state_e            state_q;
   tag_t              req_tag_q;
   idx_t              req_idx_q;
   wsel_t             req_wsel_q;
   word_t             req_wdata_q;
   logic              req_wr_q;
   way_t              way_q;
   wsel_t             cnt_q;
   logic              hit_q;
   logic              read_q;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   word_t             wdata_q;
   word_t             rdata_q;

   logic [WAYS-1:0] valid_q [SETS];
   logic [WAYS-1:0] dirty_q [SETS];
   way_t            age_q   [SETS][WAYS];
   tag_t            tag_q   [SETS][WAYS];
   word_t           data_q  [SETS][WAYS][WORDS];

   logic lookup_hit;
   way_t hit_way;
   way_t victim_way;
   way_t victim_age;
   logic fill_we;
   logic unused_addr_lsb;

   assign unused_addr_lsb = ^bus_io.cpuAddr[1:0];

   always_comb begin
      lookup_hit = 1'b0;
      hit_way    = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[req_idx_q][w] && (tag_q[req_idx_q][w] == req_tag_q)) begin
            lookup_hit = 1'b1;
            hit_way    = way_t'(w);
         end
      end
   end

   // Lowest-numbered invalid way wins; otherwise the oldest way (lowest index on a tie).
   always_comb begin
      victim_way = '0;
      victim_age = age_q[req_idx_q][0];
      for (int w = 1; w < WAYS; w++) begin
         if (age_q[req_idx_q][w] > victim_age) begin
            victim_way = way_t'(w);
            victim_age = age_q[req_idx_q][w];
         end
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[req_idx_q][w]) victim_way = way_t'(w);
      end
   end

   assign fill_we = !reset && state_q == StRefill && read_q && bus_io.done_r;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         req_tag_q   <= '0;
         req_idx_q   <= '0;
         req_wsel_q  <= '0;
         req_wdata_q <= '0;
         req_wr_q    <= 1'b0;
         way_q       <= '0;
         cnt_q       <= '0;
         hit_q       <= 1'b0;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
         end
      end else begin
         hit_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // hit_q still high means the CPU has not yet dropped the serviced request.
               if (!hit_q && (bus_io.cpuRead || bus_io.cpuWrite)) begin
                  req_tag_q   <= bus_io.cpuAddr[ADDR_W-1 -: TAG_W];
                  req_idx_q   <= bus_io.cpuAddr[WSEL_W+2 +: IDX_W];
                  req_wsel_q  <= bus_io.cpuAddr[2 +: WSEL_W];
                  req_wdata_q <= bus_io.cpuData;
                  req_wr_q    <= bus_io.cpuWrite && !bus_io.cpuRead;
                  state_q     <= StLookup;
               end
            end
            StLookup: begin
               cnt_q <= '0;
               if (lookup_hit) begin
                  way_q   <= hit_way;
                  state_q <= StResp;
               end else begin
                  way_q   <= victim_way;
                  state_q <= dirty_q[req_idx_q][victim_way] ? StWb : StRefill;
               end
            end
            StWb: begin
               if (write_q) begin
                  if (bus_io.done_w) begin
                     write_q <= 1'b0;
                     cnt_q   <= cnt_q + 1'b1;
                     if (cnt_q == LastWord) state_q <= StRefill;
                  end
               end else begin
                  write_q <= 1'b1;
                  addr_q  <= {tag_q[req_idx_q][way_q], req_idx_q, cnt_q, 2'b00};
                  wdata_q <= data_q[req_idx_q][way_q][cnt_q];
               end
            end
            StRefill: begin
               if (read_q) begin
                  if (bus_io.done_r) begin
                     read_q <= 1'b0;
                     cnt_q  <= cnt_q + 1'b1;
                     if (cnt_q == LastWord) begin
                        valid_q[req_idx_q][way_q] <= 1'b1;
                        dirty_q[req_idx_q][way_q] <= 1'b0;
                        state_q                   <= StResp;
                     end
                  end
               end else begin
                  read_q <= 1'b1;
                  addr_q <= {req_tag_q, req_idx_q, cnt_q, 2'b00};
               end
            end
            StResp: begin
               hit_q   <= 1'b1;
               rdata_q <= req_wr_q ? req_wdata_q : data_q[req_idx_q][way_q][req_wsel_q];
               if (req_wr_q) dirty_q[req_idx_q][way_q] <= 1'b1;
               for (int w = 0; w < WAYS; w++) begin
                  if (way_t'(w) == way_q) begin
                     age_q[req_idx_q][w] <= '0;
                  end else if (age_q[req_idx_q][w] <= age_q[req_idx_q][way_q] &&
                               age_q[req_idx_q][w] != OldestAge) begin
                     age_q[req_idx_q][w] <= age_q[req_idx_q][w] + 1'b1;
                  end
               end
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (fill_we) begin
         data_q[req_idx_q][way_q][cnt_q] <= bus_io.memData;
         if (cnt_q == LastWord) tag_q[req_idx_q][way_q] <= req_tag_q;
      end else if (!reset && state_q == StResp && req_wr_q) begin
         data_q[req_idx_q][way_q][req_wsel_q] <= req_wdata_q;
      end
   end

   assign bus_io.hit   = hit_q;
   assign bus_io.rData = rdata_q;
   assign bus_io.read  = read_q;
   assign bus_io.write = write_q;
   assign bus_io.addr  = addr_q;
   assign bus_io.wData = wdata_q;
endmodule

// File: tb/tb_assoc_cache.sv
// Scoreboarded bench for assoc_cache: expected memory transfers and hits are queued
// at issue time and a negedge monitor compares them against what the cache emits.
module tb_assoc_cache;
   localparam int unsigned ADDR_W = 10;
   localparam int unsigned WORD_W = 32;

   typedef enum int {EvHit, EvRd, EvWr} ev_kind_e;
   typedef struct {
      ev_kind_e          kind;
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] data;
      bit                chk;
   } ev_t;

   logic              clock = 1'b0;
   logic              reset;
   ev_t               exp_q[$];
   int                checks = 0;
   int                passed = 0;
   logic [WORD_W-1:0] mem [256];

   always #5 clock = ~clock;

   assoc_cache_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

   assoc_cache #(
      .ADDR_W(ADDR_W), .WORD_W(WORD_W), .SETS(4), .WAYS(2), .WORDS(4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus_io(bus.slave)
   );

   task automatic check(input string name, input logic [WORD_W-1:0] act,
                        input logic [WORD_W-1:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
   endtask

   function automatic void push(ev_kind_e k, logic [ADDR_W-1:0] a, logic [WORD_W-1:0] d,
                                bit c);
      ev_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      e.chk  = c;
      exp_q.push_back(e);
   endfunction

   function automatic void push_fill(logic [ADDR_W-1:0] base);
      for (int i = 0; i < 4; i++) push(EvRd, base + ADDR_W'(4 * i), '0, 1'b0);
   endfunction

   task automatic observe(input ev_kind_e k, input logic [ADDR_W-1:0] a,
                          input logic [WORD_W-1:0] d);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         $display("FAIL unexpected event: kind %0d addr 0x%03h data 0x%08h, required none",
                  k, a, d);
         return;
      end
      e = exp_q.pop_front();
      check("event kind", 32'(k), 32'(e.kind));
      if (k != EvHit) check("mem addr", 32'(a), 32'(e.addr));
      if (e.chk) check("event data", d, e.data);
   endtask

   // Monitor: memory request rising edges and hit pulses, in the order the cache emits them.
   initial begin
      logic rd_prev;
      logic wr_prev;
      rd_prev = 1'b0;
      wr_prev = 1'b0;
      forever begin
         @(negedge clock);
         if (bus.read && !rd_prev) observe(EvRd, bus.addr, '0);
         if (bus.write && !wr_prev) observe(EvWr, bus.addr, bus.wData);
         if (bus.hit) observe(EvHit, '0, bus.rData);
         rd_prev = bus.read;
         wr_prev = bus.write;
      end
   end

   // Memory model: done pulses 3 cycles after a request is raised.
   initial begin
      logic              is_w;
      logic [ADDR_W-1:0] a;
      logic [WORD_W-1:0] d;
      bus.done_r  = 1'b0;
      bus.done_w  = 1'b0;
      bus.memData = '0;
      forever begin
         @(negedge clock);
         if (bus.read || bus.write) begin
            is_w = bus.write;
            a    = bus.addr;
            d    = bus.wData;
            repeat (2) @(negedge clock);
            if (is_w) begin
               mem[a[9:2]] = d;
               bus.done_w  = 1'b1;
            end else begin
               bus.memData = mem[a[9:2]];
               bus.done_r  = 1'b1;
            end
            @(negedge clock);
            bus.done_r = 1'b0;
            bus.done_w = 1'b0;
         end
      end
   end

   task automatic cpu_op(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [WORD_W-1:0] d, output int lat);
      int n;
      n = 0;
      @(negedge clock);
      bus.cpuRead  = rd;
      bus.cpuWrite = wr;
      bus.cpuAddr  = a;
      bus.cpuData  = d;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.hit && n < 400);
      if (!bus.hit) begin
         checks++;
         $display("FAIL hit timeout @0x%03h: got no hit in %0d cycles, required a hit", a, n);
      end
      bus.cpuRead  = 1'b0;
      bus.cpuWrite = 1'b0;
      lat = n;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " hit"}, 32'(bus.hit), 32'd0);
      check({tag, " read"}, 32'(bus.read), 32'd0);
      check({tag, " write"}, 32'(bus.write), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion, required $finish before 400us");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n;
      for (int i = 0; i < 256; i++) mem[i] = 32'(i * 4);
      reset        = 1'b1;
      bus.cpuRead  = 1'b0;
      bus.cpuWrite = 1'b0;
      bus.cpuAddr  = '0;
      bus.cpuData  = '0;
      repeat (3) @(negedge clock);
      check_idle_outputs("reset");
      check("reset addr", 32'(bus.addr), 32'd0);
      check("reset wData", bus.wData, 32'd0);
      check("reset rData", bus.rData, 32'd0);
      reset = 1'b0;

      // Cold read miss, then a hit in the same block.
      push_fill(10'h010); push(EvHit, '0, 32'h014, 1'b1);
      cpu_op(1'b1, 1'b0, 10'h014, '0, lat);
      push(EvHit, '0, 32'h018, 1'b1);
      cpu_op(1'b1, 1'b0, 10'h018, '0, lat);
      check("read hit latency", 32'(lat), 32'd3);

      // Write-allocate in set 2, then read the merged and untouched words.
      push_fill(10'h020); push(EvHit, '0, '0, 1'b0);
      cpu_op(1'b0, 1'b1, 10'h020, 32'h0A5A5A5A, lat);
      push(EvHit, '0, 32'h0A5A5A5A, 1'b1);
      cpu_op(1'b1, 1'b0, 10'h020, '0, lat);
      push(EvHit, '0, 32'h024, 1'b1);
      cpu_op(1'b1, 1'b0, 10'h024, '0, lat);

      // Write hit dirties way 0; two more tags in set 1 force its write-back.
      push(EvHit, '0, '0, 1'b0);
      cpu_op(1'b0, 1'b1, 10'h014, 32'hDEADBEEF, lat);
      check("write hit latency", 32'(lat), 32'd3);
      push(EvHit, '0, 32'hDEADBEEF, 1'b1);
      cpu_op(1'b1, 1'b0, 10'h014, '0, lat);
      push_fill(10'h050); push(EvHit, '0, 32'h050, 1'b1);
      cpu_op(1'b1, 1'b0, 10'h050, '0, lat);
      push(EvWr, 10'h010, 32'h010, 1'b1);
      push(EvWr, 10'h014, 32'hDEADBEEF, 1'b1);
      push(EvWr, 10'h018, 32'h018, 1'b1);
      push(EvWr, 10'h01C, 32'h01C, 1'b1);
      push_fill(10'h090); push(EvHit, '0, 32'h090, 1'b1);
      cpu_op(1'b1, 1'b0, 10'h090, '0, lat);

      // LRU sequence: clean evictions emit no writes.
      push_fill(10'h010); push(EvHit, '0, 32'h010, 1'b1);
      cpu_op(1'b1, 1'b0, 10'h010, '0, lat);
      push_fill(10'h050); push(EvHit, '0, 32'h050, 1'b1);
      cpu_op(1'b1, 1'b0, 10'h050, '0, lat);
      push(EvHit, '0, 32'h010, 1'b1);
      cpu_op(1'b1, 1'b0, 10'h010, '0, lat);
      check("LRU re-hit latency", 32'(lat), 32'd3);
      push_fill(10'h090); push(EvHit, '0, 32'h090, 1'b1);
      cpu_op(1'b1, 1'b0, 10'h090, '0, lat);
      push(EvHit, '0, 32'hDEADBEEF, 1'b1);
      cpu_op(1'b1, 1'b0, 10'h014, '0, lat);

      // Reset while the second refill word is outstanding.
      push(EvRd, 10'h110, '0, 1'b0);
      push(EvRd, 10'h114, '0, 1'b0);
      @(negedge clock);
      bus.cpuRead = 1'b1;
      bus.cpuAddr = 10'h110;
      n = 0;
      while (!(bus.read && bus.addr == 10'h114) && n < 400) begin
         @(negedge clock);
         n++;
      end
      if (n >= 400) begin
         checks++;
         $display("FAIL refill word 1 timeout: got none in %0d cycles, required read @0x114", n);
      end
      reset       = 1'b1;
      bus.cpuRead = 1'b0;
      @(negedge clock);
      check_idle_outputs("mid-op reset");
      @(negedge clock);
      check("mid-op reset addr", 32'(bus.addr), 32'd0);
      check("mid-op reset rData", bus.rData, 32'd0);
      reset = 1'b0;
      repeat (6) @(negedge clock);
      push_fill(10'h010); push(EvHit, '0, 32'h010, 1'b1);
      cpu_op(1'b1, 1'b0, 10'h010, '0, lat);

      // Read and write both high acts as a read; the line must stay clean.
      push(EvHit, '0, 32'hDEADBEEF, 1'b1);
      cpu_op(1'b1, 1'b1, 10'h014, 32'h12345678, lat);
      push_fill(10'h050); push(EvHit, '0, 32'h050, 1'b1);
      cpu_op(1'b1, 1'b0, 10'h050, '0, lat);
      push_fill(10'h090); push(EvHit, '0, 32'h090, 1'b1);
      cpu_op(1'b1, 1'b0, 10'h090, '0, lat);
      push_fill(10'h010); push(EvHit, '0, 32'hDEADBEEF, 1'b1);
      cpu_op(1'b1, 1'b0, 10'h014, '0, lat);

      repeat (10) @(negedge clock);
      check_idle_outputs("final idle");
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
